ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I core. Consumes the decoded operand bundle from the id_ex pipeline register and computes the result for ADDI, ADD/SUB, branches, JAL, JALR, LUI and AUIPC.
- Registers the write-back triple toward the register file and the branch/jump redirect toward the fetch controller.
- Squashes wrong-path instructions already in flight after a taken redirect.

---
 rtl/ex_stage_pkg.sv | 43 ++++
 rtl/ex_branch_cmp.sv | 23 ++
 rtl/ex_stage.sv | 130 +++++++++++++
 tb/tb_ex_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - RV32I execute-stage opcode constants and immediate helpers
package ex_stage_pkg;

    localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
    localparam logic [6:0] INST_JAL      = 7'b1101111;
    localparam logic [6:0] INST_JALR     = 7'b1100111;
    localparam logic [6:0] INST_LUI      = 7'b0110111;
    localparam logic [6:0] INST_AUIPC    = 7'b0010111;

    localparam logic [2:0] INST_ADDI     = 3'b000;
    localparam logic [2:0] INST_ADD_SUB  = 3'b000;
    localparam logic [2:0] INST_JALR_F3  = 3'b000;
    localparam logic [2:0] INST_BEQ      = 3'b000;
    localparam logic [2:0] INST_BNE      = 3'b001;
    localparam logic [2:0] INST_BLT      = 3'b100;
    localparam logic [2:0] INST_BGE      = 3'b101;
    localparam logic [2:0] INST_BLTU     = 3'b110;
    localparam logic [2:0] INST_BGEU     = 3'b111;

    localparam logic [6:0] FUNCT7_ADD    = 7'b0000000;
    localparam logic [6:0] FUNCT7_SUB    = 7'b0100000;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/ex_branch_cmp.sv
// rtl/ex_branch_cmp.sv - combinational branch condition evaluation
module ex_branch_cmp (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [2:0]  funct3,
    output logic        taken
);
    import ex_stage_pkg::*;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            INST_BEQ:  taken = (op1 == op2);
            INST_BNE:  taken = (op1 != op2);
            INST_BLT:  taken = ($signed(op1) <  $signed(op2));
            INST_BGE:  taken = ($signed(op1) >= $signed(op2));
            INST_BLTU: taken = (op1 <  op2);
            INST_BGEU: taken = (op1 >= op2);
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage: ALU result, redirect and wrong-path squash
module ex_stage #(
    parameter int          FLUSH_DEPTH = 2,
    parameter logic [31:0] NOP_INST    = ex_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_rd_data_o,
    output logic        wb_reg_wen_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        flush_busy_o
);
    import ex_stage_pkg::*;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  flush_cnt;
    logic        squash;
    logic        br_taken;
    logic        wen_c;
    logic [31:0] data_c;
    logic        jump_c;
    logic [31:0] target_c;
    logic        do_write;
    logic        do_jump;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign squash = (flush_cnt != 2'd0);

    ex_branch_cmp u_branch_cmp (
        .op1    (op1_i),
        .op2    (op2_i),
        .funct3 (funct3),
        .taken  (br_taken)
    );

    always_comb begin
        wen_c    = 1'b0;
        data_c   = 32'd0;
        jump_c   = 1'b0;
        target_c = 32'd0;
        if (inst_i != NOP_INST) begin
            case (opcode)
                INST_TYPE_I: begin
                    if (funct3 == INST_ADDI) begin
                        wen_c  = 1'b1;
                        data_c = op1_i + op2_i;
                    end
                end
                INST_TYPE_R_M: begin
                    if (funct3 == INST_ADD_SUB && funct7 == FUNCT7_ADD) begin
                        wen_c  = 1'b1;
                        data_c = op1_i + op2_i;
                    end else if (funct3 == INST_ADD_SUB && funct7 == FUNCT7_SUB) begin
                        wen_c  = 1'b1;
                        data_c = op1_i - op2_i;
                    end
                end
                INST_TYPE_B: begin
                    // Unsupported branch funct3 values never report taken.
                    jump_c   = br_taken;
                    target_c = inst_addr_i + imm_b(inst_i);
                end
                INST_JAL: begin
                    wen_c    = 1'b1;
                    data_c   = inst_addr_i + 32'd4;
                    jump_c   = 1'b1;
                    target_c = inst_addr_i + imm_j(inst_i);
                end
                INST_JALR: begin
                    if (funct3 == INST_JALR_F3) begin
                        wen_c    = 1'b1;
                        data_c   = inst_addr_i + 32'd4;
                        jump_c   = 1'b1;
                        target_c = (op1_i + imm_i(inst_i)) & ~32'd1;
                    end
                end
                INST_LUI: begin
                    wen_c  = 1'b1;
                    data_c = imm_u(inst_i);
                end
                INST_AUIPC: begin
                    wen_c  = 1'b1;
                    data_c = inst_addr_i + imm_u(inst_i);
                end
                default: ;
            endcase
        end
    end

    assign do_write = wen_c & reg_wen_i & (rd_addr_i != 5'd0) & ~squash;
    assign do_jump  = jump_c & ~squash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd_addr_o <= 5'd0;
            wb_rd_data_o <= 32'd0;
            wb_reg_wen_o <= 1'b0;
            jump_en_o    <= 1'b0;
            jump_addr_o  <= 32'd0;
            flush_cnt    <= 2'd0;
        end else begin
            wb_reg_wen_o <= do_write;
            wb_rd_addr_o <= do_write ? rd_addr_i : 5'd0;
            wb_rd_data_o <= do_write ? data_c : 32'd0;
            jump_en_o    <= do_jump;
            jump_addr_o  <= do_jump ? target_c : 32'd0;
            // A redirect only reloads when the window is already closed.
            if (do_jump) begin
                flush_cnt <= 2'(FLUSH_DEPTH);
            end else if (squash) begin
                flush_cnt <= flush_cnt - 2'd1;
            end
        end
    end

    assign flush_busy_o = (flush_cnt != 2'd0);

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed and randomized checks of ex_stage against a behavioural model
module tb_ex_stage;

    localparam int FLUSH_DEPTH = 2;

    localparam int K_ADDI  = 0;
    localparam int K_R     = 1;
    localparam int K_BR    = 2;
    localparam int K_JAL   = 3;
    localparam int K_JALR  = 4;
    localparam int K_LUI   = 5;
    localparam int K_AUIPC = 6;
    localparam int K_BAD   = 7;
    localparam int K_NOP   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_rd_data_o;
    logic        wb_reg_wen_o;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        flush_busy_o;

    int n_assert = 0;
    int n_fail   = 0;
    int squash_left = 0;

    ex_stage #(.FLUSH_DEPTH(FLUSH_DEPTH), .NOP_INST(32'h0000_0013)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .rd_addr_i    (rd_addr_i),
        .reg_wen_i    (reg_wen_i),
        .wb_rd_addr_o (wb_rd_addr_o),
        .wb_rd_data_o (wb_rd_data_o),
        .wb_reg_wen_o (wb_reg_wen_o),
        .jump_en_o    (jump_en_o),
        .jump_addr_o  (jump_addr_o),
        .flush_busy_o (flush_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wen"},  32'(wb_reg_wen_o), 32'd0);
        check({tag, ".rd"},   32'(wb_rd_addr_o), 32'd0);
        check({tag, ".data"}, wb_rd_data_o,      32'd0);
        check({tag, ".jump"}, 32'(jump_en_o),    32'd0);
        check({tag, ".addr"}, jump_addr_o,       32'd0);
        check({tag, ".busy"}, 32'(flush_busy_o), 32'd0);
    endtask

    // imm is the sign-extended immediate value (U-type: the 20-bit field);
    // for K_BAD, f7 carries the unsupported opcode.
    task automatic run(input string tag, input int kind, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm, input logic [4:0] rd,
                       input logic wen, input logic [31:0] pc,
                       input logic [31:0] op1, input logic [31:0] op2);
        logic [31:0] inst;
        logic        writes;
        logic [31:0] ed;
        logic        ej;
        logic [31:0] ea;
        logic        ew;
        writes = 1'b0; ed = 32'd0; ej = 1'b0; ea = 32'd0;
        case (kind)
            K_ADDI:  inst = {imm[11:0], 5'd3, f3, rd, 7'h13};
            K_R:     inst = {f7, 5'd4, 5'd3, f3, rd, 7'h33};
            K_BR:    inst = {imm[12], imm[10:5], 5'd4, 5'd3, f3, imm[4:1], imm[11], 7'h63};
            K_JAL:   inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
            K_JALR:  inst = {imm[11:0], 5'd3, f3, rd, 7'h67};
            K_LUI:   inst = {imm[19:0], rd, 7'h37};
            K_AUIPC: inst = {imm[19:0], rd, 7'h17};
            K_BAD:   inst = {imm[24:0], f7};
            default: inst = 32'h0000_0013;
        endcase
        case (kind)
            K_ADDI: if (f3 == 3'd0) begin writes = 1'b1; ed = op1 + op2; end
            K_R: begin
                if (f3 == 3'd0 && f7 == 7'd0)  begin writes = 1'b1; ed = op1 + op2; end
                if (f3 == 3'd0 && f7 == 7'd32) begin writes = 1'b1; ed = op1 - op2; end
            end
            K_BR: begin
                case (f3)
                    3'd0: ej = (op1 == op2);
                    3'd1: ej = (op1 != op2);
                    3'd4: ej = (int'(op1) <  int'(op2));
                    3'd5: ej = (int'(op1) >= int'(op2));
                    3'd6: ej = (op1 <  op2);
                    3'd7: ej = (op1 >= op2);
                    default: ej = 1'b0;
                endcase
                ea = pc + imm;
            end
            K_JAL: begin writes = 1'b1; ed = pc + 4; ej = 1'b1; ea = pc + imm; end
            K_JALR: if (f3 == 3'd0) begin
                writes = 1'b1; ed = pc + 4; ej = 1'b1; ea = (op1 + imm) & 32'hFFFF_FFFE;
            end
            K_LUI:   begin writes = 1'b1; ed = imm * 4096; end
            K_AUIPC: begin writes = 1'b1; ed = pc + imm * 4096; end
            default: ;
        endcase
        if (squash_left > 0) begin
            writes = 1'b0;
            ej = 1'b0;
            squash_left--;
        end else if (ej) begin
            squash_left = FLUSH_DEPTH;
        end
        ew = writes && wen && (rd != 5'd0);
        inst_i = inst; inst_addr_i = pc; op1_i = op1; op2_i = op2;
        rd_addr_i = rd; reg_wen_i = wen;
        @(posedge clk);
        #1;
        check({tag, ".wen"},  32'(wb_reg_wen_o), 32'(ew));
        check({tag, ".rd"},   32'(wb_rd_addr_o), ew ? 32'(rd) : 32'd0);
        check({tag, ".data"}, wb_rd_data_o,      ew ? ed : 32'd0);
        check({tag, ".jump"}, 32'(jump_en_o),    32'(ej));
        if (ej) check({tag, ".addr"}, jump_addr_o, ea);
        check({tag, ".busy"}, 32'(flush_busy_o), 32'(squash_left != 0));
    endtask

    task automatic addi(input string tag, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        run(tag, K_ADDI, 3'd0, 7'd0, 32'd0, rd, 1'b1, 32'h40, a, b);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) run("nop", K_NOP, 3'd0, 7'd0, 32'd0, 5'd0, 1'b1, 32'h0, 32'd1, 32'd2);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          k;
        logic [6:0]  bad_ops [4];
        bad_ops[0] = 7'h03; bad_ops[1] = 7'h23; bad_ops[2] = 7'h0f; bad_ops[3] = 7'h73;

        rst_n = 1'b0;
        inst_i = 32'h0000_0013; inst_addr_i = 32'd0; op1_i = 32'd0; op2_i = 32'd0;
        rd_addr_i = 5'd0; reg_wen_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        addi("addi_ovf", 5'd5, 32'h7FFF_FFFF, 32'd1);
        run("sub_neg", K_R, 3'd0, 7'd32, 32'd0, 5'd6, 1'b1, 32'h44, 32'd0, 32'd1);
        addi("addi_x0", 5'd0, 32'h1234, 32'h1);
        run("r_bad_f7", K_R, 3'd0, 7'd1, 32'd0, 5'd7, 1'b1, 32'h48, 32'd3, 32'd4);

        run("blt", K_BR, 3'd4, 7'd0, -32'sd8, 5'd0, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1);
        nops(2);
        run("bltu", K_BR, 3'd6, 7'd0, -32'sd8, 5'd0, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'd1);

        run("jal", K_JAL, 3'd0, 7'd0, 32'd16, 5'd1, 1'b1, 32'h200, 32'd0, 32'd0);
        addi("sq_x2", 5'd2, 32'd10, 32'd1);
        addi("sq_x3", 5'd3, 32'd10, 32'd2);
        addi("ok_x4", 5'd4, 32'd10, 32'd3);

        run("jalr", K_JALR, 3'd0, 7'd0, 32'd2, 5'd1, 1'b1, 32'h300, 32'h1001, 32'd0);
        nops(2);
        run("lui", K_LUI, 3'd0, 7'd0, 32'hABCDE, 5'd8, 1'b1, 32'h0, 32'd0, 32'd0);
        run("auipc", K_AUIPC, 3'd0, 7'd0, 32'd1, 5'd9, 1'b1, 32'h10, 32'd0, 32'd0);

        run("jal_a", K_JAL, 3'd0, 7'd0, 32'd8, 5'd1, 1'b1, 32'h400, 32'd0, 32'd0);
        run("jal_ignored", K_JAL, 3'd0, 7'd0, 32'd8, 5'd1, 1'b1, 32'h404, 32'd0, 32'd0);
        nops(1);
        run("jal_edge", K_JAL, 3'd0, 7'd0, -32'sd4, 5'd1, 1'b1, 32'h40c, 32'd0, 32'd0);
        nops(2);
        run("bad_op", K_BAD, 3'd0, 7'h03, 32'h0123_4567, 5'd10, 1'b1, 32'h500, 32'd1, 32'd1);

        run("jal_rst", K_JAL, 3'd0, 7'd0, 32'd32, 5'd1, 1'b1, 32'h600, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        squash_left = 0;
        rst_n = 1'b1;
        addi("after_rst", 5'd1, 32'd5, 32'd6);

        for (int i = 0; i < 300; i++) begin
            r = $urandom;
            k = $urandom_range(0, 8);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3)));
            f3 = 3'd0;
            f7 = 7'd0;
            imm = 32'd0;
            case (k)
                K_ADDI, K_JALR: begin
                    imm = {{20{r[11]}}, r[11:0]};
                    if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
                end
                K_R: begin
                    f7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'd0 : 7'd32);
                    if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
                end
                K_BR:  begin imm = {{19{r[12]}}, r[12:1], 1'b0}; f3 = 3'($urandom); end
                K_JAL: imm = {{11{r[20]}}, r[20:1], 1'b0};
                K_LUI, K_AUIPC: imm = {12'd0, r[19:0]};
                K_BAD: begin imm = $urandom; f7 = bad_ops[$urandom_range(0, 3)]; end
                default: ;
            endcase
            run("rand", k, f3, f7, imm, 5'($urandom), 1'($urandom_range(0, 3) != 0),
                {$urandom, 2'b00}, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
